acc_wrap_monitor: RTL and testbench
===================================

ACC_WRAP_MONITOR -- requirements
Module: acc_wrap_monitor

Interface
REQ-001 Parameter WRAP_W, default 8, width of the wrap counter.
REQ-002 Parameter ACC_W, default 6, width of the accumulator word consumed.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 i_rst_n  input  1  reset, asynchronous, active-low.
REQ-005 i_acc_data  input  ACC_W  registered accumulator value from the upstream unsigned accumulator.
REQ-006 i_acc_carry  input  1  upstream adder carry; high in the cycle whose edge loads a wrapped value.
REQ-007 i_start  input  1  pulse: begin a monitoring run.
REQ-008 i_stop  input  1  pulse: end the run and produce a report.
REQ-009 i_thr  input  WRAP_W  wrap-count alarm threshold; 0 disables the alarm.
REQ-010 i_rpt_ready  input  1  report consumer ready.
REQ-011 o_ext_data  output  WRAP_W+ACC_W  extended total {wrap_cnt, i_acc_data}, combinational concat.
REQ-012 o_wrap_cnt  output  WRAP_W  current wrap count.
REQ-013 o_busy  output  1  high in RUN or ALARM.
REQ-014 o_alarm  output  1  high in ALARM.
REQ-015 o_sat  output  1  sticky: wrap counter saturated this run.
REQ-016 o_rpt_valid / o_rpt_data  output  1 / WRAP_W+ACC_W  report handshake and snapshot.
REQ-017 o_peak  output  ACC_W  maximum i_acc_data seen this run (see Configuration).

Function
REQ-018 FSM states IDLE, RUN, ALARM, REPORT; one state register.
REQ-019 IDLE: i_start -> RUN, wrap_cnt, o_sat, and o_peak cleared on that edge; i_stop ignored.
REQ-020 RUN/ALARM: on each edge with i_acc_carry=1, wrap_cnt increments by 1, keeping it aligned with the wrapped i_acc_data loaded upstream on the same edge.
REQ-021 Saturation: at 2^WRAP_W-1 further carries leave wrap_cnt unchanged and set o_sat until the next i_start.
REQ-022 RUN -> ALARM on the edge where i_thr!=0 and the next wrap_cnt >= i_thr; ALARM stays until i_stop.
REQ-023 RUN/ALARM: i_stop -> REPORT; o_rpt_data latches {next wrap_cnt, i_acc_data}, counting a carry in that same cycle; i_start ignored.
REQ-024 REPORT: o_rpt_valid=1 and o_rpt_data held stable until a cycle with i_rpt_ready=1, then -> IDLE with o_rpt_valid=0 on the next edge; carries ignored.
REQ-025 Simultaneous i_start and i_stop: start wins in IDLE; stop wins in RUN/ALARM.
REQ-026 Outside RUN/ALARM, wrap_cnt holds its value.

Reset
REQ-027 Reset forces IDLE and zeroes wrap_cnt, o_sat, o_rpt_valid, o_rpt_data, o_peak; o_busy=o_alarm=0; reset mid-REPORT drops the report.
REQ-028 Reset release requires no synchronizer inside this block.

Configuration
REQ-029 Macro ACC_MON_PEAK_EN defined: o_peak updates to max(o_peak, i_acc_data) on each edge in RUN/ALARM.
REQ-030 ACC_MON_PEAK_EN undefined: no peak register; o_peak tied to 0; all else identical.

Structure
REQ-031 Package acc_mon_pkg holds the state encoding typedef, the WRAP_W/ACC_W defaults, and derived EXT_W=WRAP_W+ACC_W.
REQ-032 Sub-module wrap_counter: saturating WRAP_W counter with clr, inc, sat-flag; instantiated once.

Verification
REQ-033 Reset then i_start, 3 carry pulses, i_stop -> o_rpt_valid=1, o_rpt_data={8'd3, i_acc_data}, ready high -> IDLE next cycle.
REQ-034 i_thr=2, two carries in RUN -> o_alarm=1 on the second carry's edge; i_stop -> REPORT with wrap field 2.
REQ-035 260 carries, WRAP_W=8 -> o_wrap_cnt=255, o_sat=1; next i_start clears both.
REQ-036 In REPORT, hold i_rpt_ready=0 for 5 cycles with carries -> o_rpt_data stable, o_wrap_cnt unchanged.
REQ-037 i_stop coincident with a carry at count 4 -> snapshot wrap field 5; i_start+i_stop in IDLE -> RUN.
REQ-038 Assert i_rst_n=0 mid-REPORT -> o_rpt_valid=0 immediately; with ACC_MON_PEAK_EN, data 10,40,7 -> o_peak=40.

Source files
------------

// File: rtl/acc_mon_pkg.sv
// Shared types and defaults for the accumulator wrap monitor.
// Build option: ACC_MON_PEAK_EN enables the run peak tracker.
package acc_mon_pkg;

  localparam int WRAP_W_DEF = 8;
  localparam int ACC_W_DEF  = 6;
  localparam int EXT_W      = WRAP_W_DEF + ACC_W_DEF;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_ALARM  = 2'd2,
    S_REPORT = 2'd3
  } mon_state_e;

endpackage

// File: rtl/wrap_counter.sv
// Saturating wrap counter with clear, increment and sticky
// saturation flag; exposes next value for same-edge snapshots.
import acc_mon_pkg::*;

module wrap_counter #(
  parameter int W = WRAP_W_DEF
) (
  input  logic         clk,
  input  logic         i_rst_n,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o,
  output logic [W-1:0] nxt_o,
  output logic         sat_o
);

  logic [W-1:0] cnt_q, cnt_d;
  logic         sat_q, sat_d;

  // Next count: clear wins, increments stop at all-ones.
  always_comb begin
    cnt_d = cnt_q;
    sat_d = sat_q;
    if (clr_i) begin
      cnt_d = '0;
      sat_d = 1'b0;
    end else if (inc_i) begin
      if (&cnt_q) sat_d = 1'b1;
      else        cnt_d = cnt_q + 1'b1;
    end
  end

  // Count and sticky flag registers.
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_q <= '0;
      sat_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      sat_q <= sat_d;
    end
  end

  assign cnt_o = cnt_q;
  assign nxt_o = cnt_d;
  assign sat_o = sat_q;

endmodule

// File: rtl/acc_wrap_monitor.sv
// Extends an upstream accumulator with a wrap count, alarm and report.
// Build option: ACC_MON_PEAK_EN adds the per-run peak register.
import acc_mon_pkg::*;

module acc_wrap_monitor #(
  parameter int WRAP_W = WRAP_W_DEF,
  parameter int ACC_W  = ACC_W_DEF
) (
  input  logic                    clk,
  input  logic                    i_rst_n,
  input  logic [ACC_W-1:0]        i_acc_data,
  input  logic                    i_acc_carry,
  input  logic                    i_start,
  input  logic                    i_stop,
  input  logic [WRAP_W-1:0]       i_thr,
  input  logic                    i_rpt_ready,
  output logic [WRAP_W+ACC_W-1:0] o_ext_data,
  output logic [WRAP_W-1:0]       o_wrap_cnt,
  output logic                    o_busy,
  output logic                    o_alarm,
  output logic                    o_sat,
  output logic                    o_rpt_valid,
  output logic [WRAP_W+ACC_W-1:0] o_rpt_data,
  output logic [ACC_W-1:0]        o_peak
);

  localparam int XW = WRAP_W + ACC_W;

  mon_state_e         state_q;
  logic               busy_q, alarm_q, rv_q;
  logic [XW-1:0]      rd_q;
  logic               running, clr, inc;
  logic [WRAP_W-1:0]  cnt, nxt;

  assign running = (state_q == S_RUN) || (state_q == S_ALARM);
  assign clr     = (state_q == S_IDLE) && i_start;
  assign inc     = running && i_acc_carry;

  wrap_counter #(.W(WRAP_W)) u_cnt (
    .clk     (clk),
    .i_rst_n (i_rst_n),
    .clr_i   (clr),
    .inc_i   (inc),
    .cnt_o   (cnt),
    .nxt_o   (nxt),
    .sat_o   (o_sat)
  );

  // Control FSM with registered status and report outputs.
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE;
      busy_q  <= 1'b0;
      alarm_q <= 1'b0;
      rv_q    <= 1'b0;
      rd_q    <= '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (i_start) begin
            state_q <= S_RUN;
            busy_q  <= 1'b1;
          end
        end
        S_RUN, S_ALARM: begin
          if (i_stop) begin
            state_q <= S_REPORT;
            busy_q  <= 1'b0;
            alarm_q <= 1'b0;
            rv_q    <= 1'b1;
            rd_q    <= {nxt, i_acc_data};
          end else if (state_q == S_RUN && i_thr != '0
                       && nxt >= i_thr) begin
            state_q <= S_ALARM;
            alarm_q <= 1'b1;
          end
        end
        S_REPORT: begin
          if (i_rpt_ready) begin
            state_q <= S_IDLE;
            rv_q    <= 1'b0;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

`ifdef ACC_MON_PEAK_EN
  logic [ACC_W-1:0] peak_q;

  // Track the largest accumulator value seen during a run.
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      peak_q <= '0;
    end else if (clr) begin
      peak_q <= '0;
    end else if (running && i_acc_data > peak_q) begin
      peak_q <= i_acc_data;
    end
  end

  assign o_peak = peak_q;
`else
  assign o_peak = '0;
`endif

  assign o_ext_data  = {cnt, i_acc_data};
  assign o_wrap_cnt  = cnt;
  assign o_busy      = busy_q;
  assign o_alarm     = alarm_q;
  assign o_rpt_valid = rv_q;
  assign o_rpt_data  = rd_q;

endmodule

// File: tb/tb_acc_wrap_monitor.sv
// Self-checking bench for acc_wrap_monitor against a run-level model.
// Honours ACC_MON_PEAK_EN for the expected peak value.
module tb_acc_wrap_monitor;

  localparam int WW = 8;
  localparam int AW = 6;
  localparam int XW = WW + AW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [AW-1:0] data = '0;
  logic          carry = 1'b0;
  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic [WW-1:0] thr = '0;
  logic          ready = 1'b0;
  logic [XW-1:0] ext_data, rpt_data;
  logic [WW-1:0] wrap_cnt;
  logic          busy, alarm, sat, rpt_valid;
  logic [AW-1:0] peak;

  int total = 0;
  int bad = 0;

  // Model: run/alarm/report flags, wrap count, snapshot, peak.
  bit            m_run, m_alarm, m_rpt, m_sat;
  int            m_cnt;
  logic [XW-1:0] m_rd;
  int            m_peak;

  always #5 clk = ~clk;

  acc_wrap_monitor #(.WRAP_W(WW), .ACC_W(AW)) dut (
    .clk         (clk),
    .i_rst_n     (rst_n),
    .i_acc_data  (data),
    .i_acc_carry (carry),
    .i_start     (start),
    .i_stop      (stop),
    .i_thr       (thr),
    .i_rpt_ready (ready),
    .o_ext_data  (ext_data),
    .o_wrap_cnt  (wrap_cnt),
    .o_busy      (busy),
    .o_alarm     (alarm),
    .o_sat       (sat),
    .o_rpt_valid (rpt_valid),
    .o_rpt_data  (rpt_data),
    .o_peak      (peak)
  );

  function automatic int exp_peak();
`ifdef ACC_MON_PEAK_EN
    return m_peak;
`else
    return 0;
`endif
  endfunction

  task automatic model_reset();
    m_run = 0; m_alarm = 0; m_rpt = 0; m_sat = 0;
    m_cnt = 0; m_rd = '0; m_peak = 0;
  endtask

  // Advance one clock edge and apply the behavioural rules.
  task automatic step();
    @(posedge clk);
    if (!rst_n) begin
      model_reset();
    end else if (m_rpt) begin
      if (ready) m_rpt = 0;
    end else if (!m_run) begin
      if (start) begin
        m_run = 1; m_cnt = 0; m_sat = 0; m_peak = 0;
      end
    end else begin
      if (carry) begin
        if (m_cnt == (1 << WW) - 1) m_sat = 1;
        else m_cnt = m_cnt + 1;
      end
      if (int'(data) > m_peak) m_peak = int'(data);
      if (stop) begin
        m_run = 0; m_alarm = 0; m_rpt = 1;
        m_rd = {m_cnt[WW-1:0], data};
      end else if (thr != 0 && m_cnt >= int'(thr)) begin
        m_alarm = 1;
      end
    end
    #1;
  endtask

  task automatic idle_inputs();
    carry = 0; start = 0; stop = 0; ready = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 0;
    model_reset();
    repeat (2) step();
    total++;
    if ({busy, alarm, sat, rpt_valid, wrap_cnt, rpt_data, peak} !== '0) begin
      bad++;
      $display("FAIL reset_outputs got=%b/%b/%b/%b/%h/%h/%h exp=0",
               busy, alarm, sat, rpt_valid, wrap_cnt, rpt_data, peak);
    end
    @(negedge clk);
    rst_n = 1;
    #5;
  endtask

  task automatic test_basic();
    start = 1; step(); start = 0;
    total++;
    if (busy !== 1'b1) begin
      bad++; $display("FAIL basic_busy got=%b exp=1", busy);
    end
    carry = 1;
    repeat (3) step();
    carry = 0;
    total++;
    if (wrap_cnt !== 8'd3) begin
      bad++; $display("FAIL basic_cnt got=%0d exp=3", wrap_cnt);
    end
    data = 6'h2A; stop = 1; step(); stop = 0;
    total++;
    if (rpt_valid !== 1'b1 || rpt_data !== {8'd3, 6'h2A}) begin
      bad++;
      $display("FAIL basic_report got=%b/%h exp=1/%h",
               rpt_valid, rpt_data, {8'd3, 6'h2A});
    end
    ready = 1; step(); ready = 0;
    total++;
    if (rpt_valid !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL basic_to_idle got=%b/%b exp=0/0", rpt_valid, busy);
    end
  endtask

  task automatic test_alarm();
    thr = 8'd2;
    start = 1; step(); start = 0;
    carry = 1; step();
    total++;
    if (alarm !== 1'b0) begin
      bad++; $display("FAIL alarm_early got=%b exp=0", alarm);
    end
    step(); carry = 0;
    total++;
    if (alarm !== 1'b1 || busy !== 1'b1) begin
      bad++; $display("FAIL alarm_set got=%b/%b exp=1/1", alarm, busy);
    end
    stop = 1; step(); stop = 0;
    total++;
    if (rpt_data[XW-1:AW] !== 8'd2 || alarm !== 1'b0) begin
      bad++;
      $display("FAIL alarm_report got=%0d/%b exp=2/0",
               rpt_data[XW-1:AW], alarm);
    end
    ready = 1; step(); ready = 0;
    thr = 0;
  endtask

  task automatic test_saturate();
    start = 1; step(); start = 0;
    carry = 1;
    repeat (260) step();
    carry = 0;
    total++;
    if (wrap_cnt !== 8'd255 || sat !== 1'b1) begin
      bad++; $display("FAIL sat_reach got=%0d/%b exp=255/1", wrap_cnt, sat);
    end
    stop = 1; step(); stop = 0;
    ready = 1; step(); ready = 0;
    total++;
    if (wrap_cnt !== 8'd255 || sat !== 1'b1) begin
      bad++; $display("FAIL sat_idle_hold got=%0d/%b exp=255/1", wrap_cnt, sat);
    end
    start = 1; step(); start = 0;
    total++;
    if (wrap_cnt !== 8'd0 || sat !== 1'b0) begin
      bad++; $display("FAIL sat_clear got=%0d/%b exp=0/0", wrap_cnt, sat);
    end
    stop = 1; step(); stop = 0;
    ready = 1; step(); ready = 0;
  endtask

  task automatic test_report_hold();
    logic [XW-1:0] snap;
    start = 1; step(); start = 0;
    carry = 1; repeat (2) step(); carry = 0;
    data = 6'h11; stop = 1; step(); stop = 0;
    snap = {8'd2, 6'h11};
    carry = 1;
    for (int i = 0; i < 5; i++) begin
      data = 6'($urandom);
      step();
      total++;
      if (rpt_data !== snap || wrap_cnt !== 8'd2 || rpt_valid !== 1'b1) begin
        bad++;
        $display("FAIL hold_cycle%0d got=%h/%0d/%b exp=%h/2/1",
                 i, rpt_data, wrap_cnt, rpt_valid, snap);
      end
    end
    carry = 0;
    ready = 1; step(); ready = 0;
  endtask

  task automatic test_stop_carry();
    start = 1; step(); start = 0;
    carry = 1; repeat (4) step();
    data = 6'h05; stop = 1; step();
    carry = 0; stop = 0;
    total++;
    if (rpt_data !== {8'd5, 6'h05}) begin
      bad++;
      $display("FAIL stop_carry got=%h exp=%h", rpt_data, {8'd5, 6'h05});
    end
    ready = 1; step(); ready = 0;
    start = 1; stop = 1; step();
    start = 0; stop = 0;
    total++;
    if (busy !== 1'b1 || rpt_valid !== 1'b0) begin
      bad++;
      $display("FAIL start_wins got=%b/%b exp=1/0", busy, rpt_valid);
    end
    stop = 1; step(); stop = 0;
    ready = 1; step(); ready = 0;
  endtask

  task automatic test_peak_reset();
    start = 1; step(); start = 0;
    data = 6'd10; step();
    data = 6'd40; step();
    data = 6'd7;  step();
    total++;
    if (int'(peak) !== exp_peak()) begin
      bad++; $display("FAIL peak got=%0d exp=%0d", peak, exp_peak());
    end
    stop = 1; step(); stop = 0;
    total++;
    if (rpt_valid !== 1'b1) begin
      bad++; $display("FAIL pre_reset_rpt got=%b exp=1", rpt_valid);
    end
    #2 rst_n = 0;
    model_reset();
    #1;
    total++;
    if (rpt_valid !== 1'b0 || rpt_data !== '0 || peak !== '0) begin
      bad++;
      $display("FAIL async_reset got=%b/%h/%h exp=0/0/0",
               rpt_valid, rpt_data, peak);
    end
    @(negedge clk);
    rst_n = 1;
    #5;
  endtask

  task automatic test_random();
    logic [XW-1:0] got, exp;
    for (int i = 0; i < 1500; i++) begin
      data  = 6'($urandom);
      carry = ($urandom_range(0, 1) == 1);
      start = ($urandom_range(0, 9) == 0);
      stop  = ($urandom_range(0, 24) == 0);
      ready = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 49) == 0) thr = 8'($urandom_range(0, 12));
      step();
      total++;
      if ({busy, alarm, sat, rpt_valid} !== {m_run, m_alarm, m_sat, m_rpt}
          || int'(wrap_cnt) !== m_cnt
          || ext_data !== {m_cnt[WW-1:0], data}
          || int'(peak) !== exp_peak()) begin
        bad++;
        $display("FAIL rand_status%0d got=%b%b%b%b cnt=%0d pk=%0d exp=%b%b%b%b cnt=%0d pk=%0d",
                 i, busy, alarm, sat, rpt_valid, wrap_cnt, peak,
                 m_run, m_alarm, m_sat, m_rpt, m_cnt, exp_peak());
      end
      got = rpt_data;
      exp = m_rd;
      total++;
      if (got !== exp) begin
        bad++; $display("FAIL rand_rpt%0d got=%h exp=%h", i, got, exp);
      end
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_alarm();
    test_saturate();
    test_report_hold();
    test_stop_carry();
    test_peak_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
